// File: rtl/alu_result_deserializer_if.sv
// ---------------------------------------------------------------------------
// alu_result_deserializer_if
// Bundles the serial line from the ALU under test with the parallel result
// fields that the deserializer presents to the scoreboard.
//   sout         : serial line, idles high, one bit per clock
//   result_valid : one-cycle pulse, a complete response has been decoded
//   result_error : the decoded response was an error control packet
//   c_data       : reassembled 32-bit C result (held between responses)
//   alu_flags    : {Carry, Overflow, Zero, Negative} from a normal response
//   crc_ok       : received CRC3 matched the recomputed CRC3
//   err_flags    : bits [6:1] of an error control byte
//   parity_ok    : error control byte parity was correct
//   frame_error  : one-cycle pulse on a malformed packet or sequence
// The slave modport is the deserializer; the master modport is whoever drives
// the serial line and consumes the results.
// ---------------------------------------------------------------------------
interface alu_result_deserializer_if;
   logic        sout;
   logic        result_valid;
   logic        result_error;
   logic [31:0] c_data;
   logic [3:0]  alu_flags;
   logic        crc_ok;
   logic [5:0]  err_flags;
   logic        parity_ok;
   logic        frame_error;

   modport master (
      output sout,
      input  result_valid, result_error, c_data, alu_flags,
             crc_ok, err_flags, parity_ok, frame_error
   );

   modport slave (
      input  sout,
      output result_valid, result_error, c_data, alu_flags,
             crc_ok, err_flags, parity_ok, frame_error
   );
endinterface

// File: rtl/alu_result_deserializer.sv
// ---------------------------------------------------------------------------
// alu_result_deserializer
// Watches the serial output of the ALU under test and rebuilds each response
// (DATA_PKTS data packets followed by a normal control packet, or a lone
// error control packet) into parallel fields for the scoreboard.
// Packet on the line: start 0, type (0 data / 1 control), 8 payload bits MSB
// first, stop 1.
// Ports:
//   clk : sole clock, sout sampled on the rising edge
//   rst : synchronous active-high reset
//   bus : slave side of alu_result_deserializer_if (sout in, results out)
// All outputs are registered; result_valid rises the cycle after the stop
// bit of the closing control packet has been sampled.
// ---------------------------------------------------------------------------
module alu_result_deserializer #(
   parameter int DATA_PKTS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   alu_result_deserializer_if.slave   bus
);

   localparam int CNT_W = $clog2(DATA_PKTS + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_PKTS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TYPE,
      ST_PAYLOAD,
      ST_STOP
   } bit_state_t;

   bit_state_t       state;
   logic [2:0]       bit_cnt;
   logic             is_ctrl;
   logic [7:0]       byte_sr;
   logic [31:0]      c_sr;
   logic [CNT_W-1:0] pkt_cnt;

   // Serial CRC3 over {C, 0, flags}, MSB first, polynomial x^3+x+1 with a
   // zero seed. Unrolled into a small XOR tree by synthesis.
   function automatic logic [2:0] crc3_calc(input logic [36:0] vec);
      logic [2:0] crc;
      logic       fb;
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ vec[i];
         crc = {crc[1], crc[0] ^ fb, fb};
      end
      return crc;
   endfunction

   // One process holds the bit-level FSM, the packet-sequence tracking and
   // every registered output. The pulses default low each cycle so each
   // packet can raise at most one of them, and only from the STOP state.
   // A bad stop bit or any out-of-order packet clears the data count so the
   // next response starts from scratch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         bit_cnt          <= 3'd0;
         is_ctrl          <= 1'b0;
         byte_sr          <= 8'd0;
         c_sr             <= 32'd0;
         pkt_cnt          <= '0;
         bus.result_valid <= 1'b0;
         bus.result_error <= 1'b0;
         bus.c_data       <= 32'd0;
         bus.alu_flags    <= 4'd0;
         bus.crc_ok       <= 1'b0;
         bus.err_flags    <= 6'd0;
         bus.parity_ok    <= 1'b0;
         bus.frame_error  <= 1'b0;
      end else begin
         bus.result_valid <= 1'b0;
         bus.frame_error  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!bus.sout) begin
                  state <= ST_TYPE;
               end
            end
            ST_TYPE: begin
               is_ctrl <= bus.sout;
               bit_cnt <= 3'd0;
               state   <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               byte_sr <= {byte_sr[6:0], bus.sout};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               state <= ST_IDLE;
               if (!bus.sout) begin
                  bus.frame_error <= 1'b1;
                  pkt_cnt         <= '0;
               end else if (!is_ctrl) begin
                  if (pkt_cnt == FULL_CNT) begin
                     bus.frame_error <= 1'b1;
                     pkt_cnt         <= '0;
                  end else begin
                     c_sr    <= {c_sr[23:0], byte_sr};
                     pkt_cnt <= pkt_cnt + CNT_W'(1);
                  end
               end else begin
                  pkt_cnt <= '0;
                  if (!byte_sr[7]) begin
                     if (pkt_cnt == FULL_CNT) begin
                        bus.result_valid <= 1'b1;
                        bus.result_error <= 1'b0;
                        bus.c_data       <= c_sr;
                        bus.alu_flags    <= byte_sr[6:3];
                        bus.crc_ok       <= (crc3_calc({c_sr, 1'b0, byte_sr[6:3]}) == byte_sr[2:0]);
                        bus.parity_ok    <= 1'b0;
                     end else begin
                        bus.frame_error <= 1'b1;
                     end
                  end else begin
                     if (pkt_cnt == '0) begin
                        bus.result_valid <= 1'b1;
                        bus.result_error <= 1'b1;
                        bus.err_flags    <= byte_sr[6:1];
                        bus.parity_ok    <= (byte_sr[0] == ^byte_sr[7:1]);
                        bus.crc_ok       <= 1'b0;
                     end else begin
                        bus.frame_error <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_deserializer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_deserializer
// Drives packets onto sout and checks every result/frame_error pulse against
// a packet-level reference model (queue of data bytes, CRC by polynomial
// long division). Directed cases first, then randomized packet streams.
// ---------------------------------------------------------------------------
module tb_alu_result_deserializer;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   alu_result_deserializer_if bus();

   alu_result_deserializer #(.DATA_PKTS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          frame;
      int          cyc;
      bit          resErr;
      logic [31:0] c;
      logic [3:0]  flags;
      bit          crc;
      logic [5:0]  ef;
      bit          par;
   } evt_t;

   int          checkCount = 0;
   int          errorCount = 0;
   logic [7:0]  dataQ[$];
   logic [31:0] modelC = 32'd0;
   logic [3:0]  modelFlags = 4'd0;
   evt_t        expQ[$];
   evt_t        dutQ[$];

   // 10 ns clock; cyc counts rising edges so that stimulus and monitor, both
   // running on the falling edge, see a stable cycle number.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every pulse the DUT produces, together with the fields visible
   // in that cycle.
   always @(negedge clk) begin
      evt_t d;
      d = '{default: 0};
      d.cyc    = cyc;
      d.resErr = bus.result_error;
      d.c      = bus.c_data;
      d.flags  = bus.alu_flags;
      d.crc    = bus.crc_ok;
      d.ef     = bus.err_flags;
      d.par    = bus.parity_ok;
      if (bus.result_valid === 1'b1) begin
         d.frame = 1'b0;
         dutQ.push_back(d);
      end
      if (bus.frame_error === 1'b1) begin
         d.frame = 1'b1;
         dutQ.push_back(d);
      end
   end

   // Safety net so the run always ends.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation did not reach the end");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Remainder of M(x)*x^3 divided by x^3+x+1.
   function automatic logic [2:0] crcModel(input logic [36:0] m);
      logic [39:0] r;
      r = {m, 3'b000};
      for (int i = 39; i >= 3; i--) begin
         if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
      end
      return r[2:0];
   endfunction

   // Packet-level reference: what the scoreboard should see for one packet.
   task automatic modelPacket(input bit isCtrl, input logic [7:0] b, input bit stopOk, input int stopCyc);
      evt_t e;
      bit   want;
      e = '{default: 0};
      e.cyc = stopCyc + 1;
      if (!stopOk) begin
         e.frame = 1'b1;
         dataQ.delete();
      end else if (!isCtrl) begin
         if (dataQ.size() == 4) begin
            e.frame = 1'b1;
            dataQ.delete();
         end else begin
            dataQ.push_back(b);
            return;
         end
      end else if (!b[7]) begin
         if (dataQ.size() == 4) begin
            modelC     = {dataQ[0], dataQ[1], dataQ[2], dataQ[3]};
            modelFlags = b[6:3];
            e.crc      = (crcModel({modelC, 1'b0, modelFlags}) == b[2:0]);
         end else begin
            e.frame = 1'b1;
         end
         dataQ.delete();
      end else begin
         if (dataQ.size() == 0) begin
            e.resErr = 1'b1;
            e.ef     = b[6:1];
            want     = ($countones(b[7:1]) % 2) == 1;
            e.par    = (b[0] == want);
         end else begin
            e.frame = 1'b1;
         end
         dataQ.delete();
      end
      e.c     = modelC;
      e.flags = modelFlags;
      expQ.push_back(e);
   endtask

   task automatic modelReset();
      dataQ.delete();
      modelC     = 32'd0;
      modelFlags = 4'd0;
   endtask

   // Send one 11-bit packet after `gap` idle-high cycles.
   task automatic applyStimulus(input bit isCtrl, input logic [7:0] b, input bit stopOk, input int gap);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         bus.sout = 1'b1;
      end
      @(negedge clk);
      bus.sout = 1'b0;
      @(negedge clk);
      bus.sout = isCtrl;
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         bus.sout = b[i];
      end
      @(negedge clk);
      bus.sout = stopOk;
      modelPacket(isCtrl, b, stopOk, cyc);
   endtask

   task automatic sendResponse(input logic [31:0] c, input logic [3:0] flags, input logic [2:0] crcFlip, input int gap);
      logic [2:0] crc;
      crc = crcModel({c, 1'b0, flags}) ^ crcFlip;
      applyStimulus(1'b0, c[31:24], 1'b1, gap);
      applyStimulus(1'b0, c[23:16], 1'b1, 0);
      applyStimulus(1'b0, c[15:8],  1'b1, 0);
      applyStimulus(1'b0, c[7:0],   1'b1, 0);
      applyStimulus(1'b1, {1'b0, flags, crc}, 1'b1, 0);
   endtask

   task automatic settle();
      @(negedge clk);
      bus.sout = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic compareEvents(input string tag);
      int n;
      checkOutput({tag, "_event_count"}, 64'(dutQ.size()), 64'(expQ.size()));
      n = (dutQ.size() < expQ.size()) ? dutQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_event_kind"},  64'(dutQ[i].frame), 64'(expQ[i].frame));
         checkOutput({tag, "_event_cycle"}, 64'(dutQ[i].cyc),   64'(expQ[i].cyc));
         if (!expQ[i].frame && !dutQ[i].frame) begin
            checkOutput({tag, "_result_error"}, 64'(dutQ[i].resErr), 64'(expQ[i].resErr));
            checkOutput({tag, "_c_data"},       64'(dutQ[i].c),      64'(expQ[i].c));
            checkOutput({tag, "_alu_flags"},    64'(dutQ[i].flags),  64'(expQ[i].flags));
            if (expQ[i].resErr) begin
               checkOutput({tag, "_err_flags"}, 64'(dutQ[i].ef),  64'(expQ[i].ef));
               checkOutput({tag, "_parity_ok"}, 64'(dutQ[i].par), 64'(expQ[i].par));
            end else begin
               checkOutput({tag, "_crc_ok"}, 64'(dutQ[i].crc), 64'(expQ[i].crc));
            end
         end
      end
      dutQ.delete();
      expQ.delete();
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_result_valid"}, 64'(bus.result_valid), 64'd0);
      checkOutput({tag, "_result_error"}, 64'(bus.result_error), 64'd0);
      checkOutput({tag, "_frame_error"},  64'(bus.frame_error),  64'd0);
      checkOutput({tag, "_c_data"},       64'(bus.c_data),       64'd0);
      checkOutput({tag, "_alu_flags"},    64'(bus.alu_flags),    64'd0);
      checkOutput({tag, "_err_flags"},    64'(bus.err_flags),    64'd0);
      checkOutput({tag, "_crc_ok"},       64'(bus.crc_ok),       64'd0);
      checkOutput({tag, "_parity_ok"},    64'(bus.parity_ok),    64'd0);
   endtask

   initial begin
      int          kind;
      int          n;
      logic [31:0] rc;
      logic [5:0]  ef;
      logic [7:0]  b;

      rst      = 1'b1;
      bus.sout = 1'b1;
      repeat (3) @(negedge clk);
      checkResetState("por");
      rst = 1'b0;
      dutQ.delete();

      // Normal response, then the same with CRC bit 0 inverted.
      sendResponse(32'h0000_0003, 4'b0000, 3'b000, 2);
      settle();
      compareEvents("normal");
      sendResponse(32'h0000_0003, 4'b0000, 3'b001, 1);
      settle();
      compareEvents("bad_crc");

      // Error responses with correct then wrong parity, back to back.
      applyStimulus(1'b1, 8'b1100_1001, 1'b1, 2);
      applyStimulus(1'b1, 8'b1100_1000, 1'b1, 0);
      settle();
      compareEvents("err_resp");

      // Short sequence closed by a normal control packet.
      applyStimulus(1'b0, 8'h12, 1'b1, 1);
      applyStimulus(1'b0, 8'h34, 1'b1, 0);
      applyStimulus(1'b1, 8'h00, 1'b1, 0);
      settle();
      compareEvents("short_seq");

      // Five data packets in a row.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(i + 1), 1'b1, 0);
      settle();
      compareEvents("five_data");

      // Bad stop bit, then a full response right behind it.
      applyStimulus(1'b0, 8'hA5, 1'b0, 1);
      sendResponse(32'hDEAD_BEEF, 4'b1010, 3'b000, 0);
      settle();
      compareEvents("bad_stop");

      // Error control arriving mid-sequence.
      applyStimulus(1'b0, 8'h77, 1'b1, 1);
      applyStimulus(1'b1, 8'b1000_0011, 1'b1, 0);
      settle();
      compareEvents("err_mid_seq");

      // Reset after the third data packet.
      applyStimulus(1'b0, 8'h11, 1'b1, 1);
      applyStimulus(1'b0, 8'h22, 1'b1, 0);
      applyStimulus(1'b0, 8'h33, 1'b1, 0);
      @(negedge clk);
      bus.sout = 1'b1;
      rst      = 1'b1;
      modelReset();
      @(negedge clk);
      checkResetState("mid_reset");
      rst = 1'b0;
      sendResponse(32'h0102_0304, 4'b0110, 3'b000, 1);
      settle();
      compareEvents("after_reset");

      // Reset in the middle of a packet's payload.
      sendResponse(32'hCAFE_0001, 4'b0001, 3'b000, 1);
      applyStimulus(1'b0, 8'h55, 1'b1, 1);
      @(negedge clk); bus.sout = 1'b0;
      @(negedge clk); bus.sout = 1'b0;
      @(negedge clk); bus.sout = 1'b1;
      @(negedge clk); bus.sout = 1'b0;
      @(negedge clk);
      bus.sout = 1'b1;
      rst      = 1'b1;
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      sendResponse(32'h8000_00FF, 4'b1111, 3'b000, 2);
      settle();
      compareEvents("reset_mid_pkt");

      // Randomized packet streams.
      for (int it = 0; it < 60; it++) begin
         kind = int'($urandom_range(0, 9));
         if (kind <= 4) begin
            rc = $urandom();
            sendResponse(rc, 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                         int'($urandom_range(0, 3)));
         end else if (kind <= 6) begin
            ef = 6'($urandom_range(0, 63));
            b  = {1'b1, ef, 1'b0};
            b[0] = ($countones(b[7:1]) % 2 == 1) ^ ($urandom_range(0, 3) == 0);
            applyStimulus(1'b1, b, 1'b1, int'($urandom_range(0, 3)));
         end else if (kind == 7) begin
            n = int'($urandom_range(0, 5));
            for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom()), 1'b1, int'($urandom_range(0, 2)));
            applyStimulus(1'b1, {1'b0, 7'($urandom())}, 1'b1, int'($urandom_range(0, 2)));
         end else if (kind == 8) begin
            applyStimulus(($urandom_range(0, 1) == 1), 8'($urandom()), 1'b0, int'($urandom_range(0, 3)));
         end else begin
            applyStimulus(1'b0, 8'($urandom()), 1'b1, int'($urandom_range(0, 3)));
         end
         if (($urandom_range(0, 3) == 0) || (it == 59)) begin
            settle();
            compareEvents("random");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/alu_result_deserializer.md
# alu_result_deserializer

Receive-side stage of the serial-ALU testbench. It watches the DUT's serial output line and reassembles each response (four data packets plus one control packet, or a single error control packet) into parallel fields. It checks the packet CRC3 and the error parity, then presents one-cycle-valid results to the scoreboard. It sits between the DUT `sout` pin and the scoreboard.

## Interface
- `DATA_PKTS`, default 4: number of data packets in a normal response (C is sent MSB byte first).
- `clk` in 1: sole clock; `sout` is sampled on its rising edge, one bit per cycle.
- `rst` in 1: synchronous, active-high reset.
- `sout` in 1: DUT serial output; idles high.
- `result_valid` out 1: one-cycle pulse; a complete response has been decoded.
- `result_error` out 1: response was an error control packet; valid with `result_valid`.
- `c_data` out 32: reassembled C; held until the next `result_valid`.
- `alu_flags` out 4: flags from the normal control packet, as {Carry, Overflow, Zero, Negative}.
- `crc_ok` out 1: received CRC3 matches the computed CRC3 (normal responses only).
- `err_flags` out 6: bits [6:1] of the error control byte.
- `parity_ok` out 1: error control byte parity is correct (error responses only).
- `frame_error` out 1: one-cycle pulse on a malformed packet or sequence.

## Operation
- Packet format, 11 bits: start bit 0, type bit (0 = data, 1 = control), 8 payload bits MSB first, stop bit 1.
- Bit FSM: IDLE → TYPE → PAYLOAD (8 cycles, 3-bit counter) → STOP → IDLE.
  - IDLE exits when `sout`=0.
  - STOP with `sout`=0 pulses `frame_error`, discards the packet, clears the sequence, and returns to IDLE.
- Sequence tracking:
  - Each accepted data packet shifts its byte into a 32-bit register and increments `pkt_cnt` (0..4).
  - A data packet arriving when `pkt_cnt`=4 causes a `frame_error` pulse and clears the sequence.
- Control packet with byte bit 7 = 0 (normal response):
  - Valid only when `pkt_cnt`=4; otherwise `frame_error` pulses, the sequence clears, and there is no `result_valid`.
  - Normal control byte layout: {0, flags[3:0], crc3[2:0]}.
  - Computed CRC3 is taken over the 37-bit vector {C, 1'b0, flags}, MSB first, polynomial x^3+x+1, init 3'b000.
  - `crc_ok` = (computed == received).
- Control packet with byte bit 7 = 1 (error response):
  - Valid only when `pkt_cnt`=0; otherwise `frame_error` pulses.
  - `err_flags` = byte[6:1].
  - `parity_ok` = (byte[0] == ^byte[7:1]).
  - `c_data` and `alu_flags` are held unchanged.
- After any control packet (valid or not), `pkt_cnt` returns to 0.
- `result_valid` and `frame_error` are never asserted in the same cycle.

## Timing
- Reset values:
  - Bit FSM = IDLE, `pkt_cnt`=0.
  - `result_valid`=0, `result_error`=0, `frame_error`=0.
  - `c_data`=0, `alu_flags`=0, `err_flags`=0.
  - `crc_ok`=0, `parity_ok`=0.
- Latency: `result_valid` rises in the cycle after the control packet's stop bit is sampled. All result fields are updated in that same cycle.
- Back-to-back packets are supported: a start bit may be sampled in the cycle immediately after a stop bit. At most one pulse occurs per packet.
- Reset asserted mid-packet or mid-sequence:
  - All state is discarded at the next edge, with no `result_valid` and no `frame_error`.
  - Decoding restarts from IDLE; a partial packet still on the line after reset is treated as a fresh frame once `sout` idles high.
- A single-cycle low on `sout` in IDLE is always treated as a start bit; no glitch filtering.

## Test plan
- **Normal response:** send 4 data packets 0x00,0x00,0x00,0x03, then a control packet with flags 4'b0000 and correctly computed CRC3 → one `result_valid` one cycle after the stop bit, `c_data`=32'h00000003, `crc_ok`=1, `result_error`=0.
- **Corrupted CRC:** same response with CRC bit 0 inverted → `result_valid`=1, `c_data`=32'h00000003, `crc_ok`=0.
- **Error response:** single control byte 8'b1_100100_0 (ERR_DATA; parity = ^7'b1100100 = 1, so the correct byte is 8'b11001001) → `result_error`=1, `err_flags`=6'b100100, `parity_ok`=1. Repeat with the byte 8'b11001000 → `parity_ok`=0.
- **Sequence violations:** send 2 data packets, then a normal control packet → `frame_error` pulse, no `result_valid`. Send 5 data packets → `frame_error` on the fifth stop bit.
- **Bad stop bit:** data packet with stop bit 0 → `frame_error` pulse; a following valid 5-packet response decodes correctly.
- **Reset mid-sequence:** assert `rst` for 1 cycle after the 3rd data packet, then send a full valid response → all outputs 0 during reset, then exactly one `result_valid` with the correct `c_data`.
